// File: rtl/alu_core_pkg.sv
// Shared opcode encoding, run-state type and instruction field layout for alu_core_param.
// Instruction word is {op, dst, src1, src0}; field offsets scale with the operand width.
package alu_core_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_STO  = 4'd3,
        OP_BLE  = 4'd4,
        OP_JMP  = 4'd5,
        OP_CALL = 4'd6,
        OP_RET  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_OUT  = 4'd10,
        OP_IN   = 4'd11,
        OP_HALT = 4'd15
    } op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } core_st_e;

    localparam int OP_W      = 4;
    localparam int FAULT_OVF = 0;
    localparam int FAULT_UNF = 1;

    function automatic int instr_w(input int addr_w);
        return OP_W + 3 * addr_w;
    endfunction

    function automatic int src1_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int dst_lsb(input int addr_w);
        return 2 * addr_w;
    endfunction

    function automatic int op_lsb(input int addr_w);
        return 3 * addr_w;
    endfunction

endpackage

// File: rtl/alu_core_param_ret_stack.sv
// Hardware return-address stack; entry 0 is always the top, older entries shift down.
// Overflowing pushes and underflowing pops are ignored here; the core flags them.
module ret_stack #(
    parameter int IP_W        = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [IP_W-1:0] push_data_i,
    output logic [IP_W-1:0] top_o,
    output logic            full_o,
    output logic            empty_o
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IP_W-1:0]  ent_q [STACK_DEPTH];
    logic [IP_W-1:0]  ent_d [STACK_DEPTH];

    assign full_o  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign top_o   = ent_q[0];

    always_comb begin
        cnt_d = cnt_q;
        ent_d = ent_q;
        if (push_i && !full_o) begin
            cnt_d    = cnt_q + CNT_W'(1);
            ent_d[0] = push_data_i;
            for (int i = 1; i < STACK_DEPTH; i++) ent_d[i] = ent_q[i-1];
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - CNT_W'(1);
            for (int i = 0; i < STACK_DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
        end
    end

    // Only the depth counter is reset; stale entries are unreachable once it is zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    always_ff @(posedge clk_i) begin
        ent_q <= ent_d;
    end

endmodule

// File: rtl/alu_core_param.sv
// Two-stage (fetch / execute) parametrised MiniAlu core with return stack, I/O port and HALT.
// Taken branches steer oIP combinationally from execute, so there is no branch bubble.
module alu_core_param
    import alu_core_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int IP_W        = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    output logic [IP_W-1:0]            oIP,
    input  logic [instr_w(ADDR_W)-1:0] iInstruction,
    output logic [ADDR_W-1:0]          oReadAddr0,
    output logic [ADDR_W-1:0]          oReadAddr1,
    input  logic [DATA_W-1:0]          iReadData0,
    input  logic [DATA_W-1:0]          iReadData1,
    output logic                       oWriteEnable,
    output logic [ADDR_W-1:0]          oWriteAddr,
    output logic [DATA_W-1:0]          oWriteData,
    output logic                       oIOWrite,
    output logic [ADDR_W-1:0]          oIOSel,
    output logic [DATA_W-1:0]          oIOData,
    input  logic [DATA_W-1:0]          iIOData,
    output logic                       oHalted,
    output logic [1:0]                 oStackFault
);
    localparam int OP_LSB   = op_lsb(ADDR_W);
    localparam int DST_LSB  = dst_lsb(ADDR_W);
    localparam int SRC1_LSB = src1_lsb(ADDR_W);

    op_e               f_op;
    logic [ADDR_W-1:0] f_dst, f_src1, f_src0;

    assign f_op   = op_e'(iInstruction[OP_LSB +: OP_W]);
    assign f_dst  = iInstruction[DST_LSB +: ADDR_W];
    assign f_src1 = iInstruction[SRC1_LSB +: ADDR_W];
    assign f_src0 = iInstruction[ADDR_W-1:0];

    assign oReadAddr0 = f_src0;
    assign oReadAddr1 = f_src1;

    core_st_e          st_q;
    logic [IP_W-1:0]   ip_q, ip_d, ex_ip_q;
    op_e               ex_op_q;
    logic [ADDR_W-1:0] ex_dst_q, ex_src1_q, ex_src0_q;
    logic [1:0]        fault_q, fault_d;
    logic              fwd_we_q;
    logic [ADDR_W-1:0] fwd_dst_q;
    logic [DATA_W-1:0] fwd_data_q;

    logic [DATA_W-1:0] op1, op0, wr_data;
    logic [IP_W-1:0]   target, stk_top;
    logic              wr_en, io_wr, take, halt_now;
    logic              push, pop, ovf, unf, stk_full, stk_empty;

    ret_stack #(
        .IP_W        (IP_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk_i       (Clock),
        .rst_ni      (Reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (ex_ip_q + IP_W'(1)),
        .top_o       (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    always_comb begin
        // Last cycle's result bypasses the RAM, whose read was issued before that write landed.
        op1 = (fwd_we_q && fwd_dst_q == ex_src1_q) ? fwd_data_q : iReadData1;
        op0 = (fwd_we_q && fwd_dst_q == ex_src0_q) ? fwd_data_q : iReadData0;

        wr_en    = 1'b0;
        wr_data  = '0;
        io_wr    = 1'b0;
        take     = 1'b0;
        target   = IP_W'(ex_dst_q);
        push     = 1'b0;
        pop      = 1'b0;
        ovf      = 1'b0;
        unf      = 1'b0;
        halt_now = 1'b0;

        case (ex_op_q)
            OP_ADD:  begin wr_en = 1'b1; wr_data = op1 + op0; end
            OP_SUB:  begin wr_en = 1'b1; wr_data = op1 - op0; end
            OP_AND:  begin wr_en = 1'b1; wr_data = op1 & op0; end
            OP_OR:   begin wr_en = 1'b1; wr_data = op1 | op0; end
            OP_STO:  begin wr_en = 1'b1; wr_data = DATA_W'({ex_src1_q, ex_src0_q}); end
            OP_IN:   begin wr_en = 1'b1; wr_data = iIOData; end
            OP_OUT:  io_wr = 1'b1;
            OP_BLE:  take = (op1 <= op0);
            OP_JMP:  take = 1'b1;
            OP_CALL: begin
                take = 1'b1;
                ovf  = stk_full;
                push = !stk_full;
            end
            OP_RET: begin
                unf = stk_empty;
                if (!stk_empty) begin
                    pop    = 1'b1;
                    take   = 1'b1;
                    target = stk_top;
                end
            end
            OP_HALT: halt_now = 1'b1;
            default: ;
        endcase

        fault_d = fault_q;
        if (ovf) fault_d[FAULT_OVF] = 1'b1;
        if (unf) fault_d[FAULT_UNF] = 1'b1;
    end

    assign oIP  = take ? target : ip_q;
    assign ip_d = oIP + IP_W'(1);

    assign oWriteEnable = wr_en;
    assign oWriteAddr   = wr_en ? ex_dst_q : '0;
    assign oWriteData   = wr_data;
    assign oIOWrite     = io_wr;
    assign oIOSel       = io_wr ? ex_dst_q : '0;
    assign oIOData      = io_wr ? op1 : '0;
    assign oHalted      = (st_q == ST_HALT);
    assign oStackFault  = fault_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            st_q       <= ST_RUN;
            ip_q       <= '0;
            ex_ip_q    <= '0;
            ex_op_q    <= OP_NOP;
            ex_dst_q   <= '0;
            ex_src1_q  <= '0;
            ex_src0_q  <= '0;
            fault_q    <= '0;
            fwd_we_q   <= 1'b0;
            fwd_dst_q  <= '0;
            fwd_data_q <= '0;
        end else begin
            fault_q    <= fault_d;
            fwd_we_q   <= wr_en;
            fwd_dst_q  <= ex_dst_q;
            fwd_data_q <= wr_data;
            case (st_q)
                ST_RUN: begin
                    if (halt_now) begin
                        // ip_q already points at HALT+1 and is frozen from here on.
                        st_q    <= ST_HALT;
                        ex_op_q <= OP_NOP;
                    end else begin
                        ip_q      <= ip_d;
                        ex_ip_q   <= oIP;
                        ex_op_q   <= f_op;
                        ex_dst_q  <= f_dst;
                        ex_src1_q <= f_src1;
                        ex_src0_q <= f_src0;
                    end
                end
                ST_HALT: ex_op_q <= OP_NOP;
                default: st_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_core_param.sv
// Bench for alu_core_param: reset, vector table, hand-written control-flow sequences,
// and random programs checked cycle by cycle against a sequential ISA model.
module tb_alu_core_param;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] oIP;
    logic [27:0] iInstruction;
    logic [7:0]  oReadAddr0, oReadAddr1;
    logic [15:0] iReadData0, iReadData1;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddr;
    logic [15:0] oWriteData;
    logic        oIOWrite;
    logic [7:0]  oIOSel;
    logic [15:0] oIOData;
    logic [15:0] iIOData = 16'h1234;
    logic        oHalted;
    logic [1:0]  oStackFault;

    always #5 Clock = ~Clock;

    logic [27:0] rom      [256];
    logic [15:0] ram      [256];
    logic [15:0] ram_init [256];
    logic        ram_load = 1'b0;

    assign iInstruction = rom[oIP[7:0]];

    always @(posedge Clock) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
        end else if (oWriteEnable) begin
            ram[oWriteAddr] <= oWriteData;
        end
        iReadData0 <= ram[oReadAddr0];
        iReadData1 <= ram[oReadAddr1];
    end

    alu_core_param dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oIP          (oIP),
        .iInstruction (iInstruction),
        .oReadAddr0   (oReadAddr0),
        .oReadAddr1   (oReadAddr1),
        .iReadData0   (iReadData0),
        .iReadData1   (iReadData1),
        .oWriteEnable (oWriteEnable),
        .oWriteAddr   (oWriteAddr),
        .oWriteData   (oWriteData),
        .oIOWrite     (oIOWrite),
        .oIOSel       (oIOSel),
        .oIOData      (oIOData),
        .iIOData      (iIOData),
        .oHalted      (oHalted),
        .oStackFault  (oStackFault)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    // Leaves the bench at posedge+1 with Reset released; next negedge is cycle 0.
    task automatic reset_dut();
        Reset = 1'b0;
        ram_load = 1'b1;
        @(posedge Clock); #1 ram_load = 1'b0;
        @(negedge Clock);
        chk("rst_ip", oIP, 0);
        chk("rst_we", oWriteEnable, 0);
        chk("rst_io", oIOWrite, 0);
        chk("rst_halt", oHalted, 0);
        chk("rst_fault", oStackFault, 0);
        @(posedge Clock); #1 Reset = 1'b1;
    endtask

    // ---------------- ISA reference model ----------------
    logic [15:0] m_mem [256];
    logic [15:0] m_ip;
    logic [15:0] m_stk [$];
    logic [1:0]  m_flt;
    bit          m_halt;

    task automatic model_cycle(input int c);
        logic [27:0] ins;
        logic [3:0]  op;
        logic [7:0]  d, s1, s0;
        logic [15:0] a1, a0, nxt, wd;
        bit          we, io;
        chk($sformatf("c%0d_halted", c), oHalted, m_halt);
        chk($sformatf("c%0d_fault", c), oStackFault, m_flt);
        if (m_halt) begin
            chk($sformatf("c%0d_ip_halt", c), oIP, m_ip);
            chk($sformatf("c%0d_we_halt", c), oWriteEnable, 0);
            chk($sformatf("c%0d_io_halt", c), oIOWrite, 0);
            return;
        end
        ins = rom[m_ip[7:0]];
        {op, d, s1, s0} = ins;
        a1 = m_mem[s1];
        a0 = m_mem[s0];
        nxt = m_ip + 16'd1;
        we = 0; io = 0; wd = '0;
        case (op)
            4'd1:  begin we = 1; wd = a1 + a0; end
            4'd2:  begin we = 1; wd = a1 - a0; end
            4'd8:  begin we = 1; wd = a1 & a0; end
            4'd9:  begin we = 1; wd = a1 | a0; end
            4'd3:  begin we = 1; wd = {s1, s0}; end
            4'd11: begin we = 1; wd = iIOData; end
            4'd10: io = 1;
            4'd4:  if (a1 <= a0) nxt = {8'h00, d};
            4'd5:  nxt = {8'h00, d};
            4'd6: begin
                if (m_stk.size() < 4) m_stk.push_front(m_ip + 16'd1);
                else m_flt[0] = 1'b1;
                nxt = {8'h00, d};
            end
            4'd7: begin
                if (m_stk.size() > 0) nxt = m_stk.pop_front();
                else m_flt[1] = 1'b1;
            end
            4'd15: m_halt = 1;
            default: ;
        endcase
        chk($sformatf("c%0d_ip", c), oIP, nxt);
        chk($sformatf("c%0d_we", c), oWriteEnable, we);
        if (we) begin
            chk($sformatf("c%0d_waddr", c), oWriteAddr, d);
            chk($sformatf("c%0d_wdata", c), oWriteData, wd);
            m_mem[d] = wd;
        end
        chk($sformatf("c%0d_io", c), oIOWrite, io);
        if (io) begin
            chk($sformatf("c%0d_iosel", c), oIOSel, d);
            chk($sformatf("c%0d_iodata", c), oIOData, a1);
        end
        m_ip = nxt;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;    // op1 (src1)
        logic [15:0] b;    // op0 (src0)
        logic        we;
        logic [15:0] wd;
        logic [15:0] ip;
        logic        io;
    } vec_t;

    vec_t vt [13];

    initial begin
        vt[0]  = '{4'd1,  16'h0003, 16'h0004, 1'b1, 16'h0007, 16'h0003, 1'b0};
        vt[1]  = '{4'd2,  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 16'h0003, 1'b0};
        vt[2]  = '{4'd2,  16'h1000, 16'h0001, 1'b1, 16'h0FFF, 16'h0003, 1'b0};
        vt[3]  = '{4'd8,  16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 16'h0003, 1'b0};
        vt[4]  = '{4'd9,  16'hF000, 16'h000F, 1'b1, 16'hF00F, 16'h0003, 1'b0};
        vt[5]  = '{4'd1,  16'hFFFF, 16'h0001, 1'b1, 16'h0000, 16'h0003, 1'b0};
        vt[6]  = '{4'd4,  16'h0003, 16'h0003, 1'b0, 16'h0000, 16'h0020, 1'b0};
        vt[7]  = '{4'd4,  16'h0004, 16'h0003, 1'b0, 16'h0000, 16'h0003, 1'b0};
        vt[8]  = '{4'd4,  16'h0000, 16'hFFFF, 1'b0, 16'h0000, 16'h0020, 1'b0};
        vt[9]  = '{4'd4,  16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'h0003, 1'b0};
        vt[10] = '{4'd5,  16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h0020, 1'b0};
        vt[11] = '{4'd10, 16'h0007, 16'h0009, 1'b0, 16'h0000, 16'h0003, 1'b1};
        vt[12] = '{4'd13, 16'h0005, 16'h0006, 1'b0, 16'h0000, 16'h0003, 1'b0};

        for (int i = 0; i < 256; i++) ram_init[i] = 16'($urandom);

        for (int i = 0; i < 13; i++) begin
            clear_rom();
            rom[0] = mk(4'd3, 8'h01, vt[i].a[15:8], vt[i].a[7:0]);
            rom[1] = mk(4'd3, 8'h02, vt[i].b[15:8], vt[i].b[7:0]);
            rom[2] = mk(vt[i].op, 8'h20, 8'h01, 8'h02);
            reset_dut();
            repeat (4) @(negedge Clock);
            chk($sformatf("vec%0d_we", i), oWriteEnable, vt[i].we);
            if (vt[i].we) begin
                chk($sformatf("vec%0d_waddr", i), oWriteAddr, 8'h20);
                chk($sformatf("vec%0d_wdata", i), oWriteData, vt[i].wd);
            end
            chk($sformatf("vec%0d_ip", i), oIP, vt[i].ip);
            chk($sformatf("vec%0d_io", i), oIOWrite, vt[i].io);
            if (vt[i].io) chk($sformatf("vec%0d_iodata", i), oIOData, vt[i].a);
        end

        // STO then dependent ADD: r2 must come from the forwarded 5, not stale RAM.
        clear_rom();
        ram_init[1] = 16'hDEAD;
        rom[0] = mk(4'd3, 8'h01, 8'h00, 8'h05);
        rom[1] = mk(4'd1, 8'h02, 8'h01, 8'h01);
        reset_dut();
        @(negedge Clock); chk("sa_ip0", oIP, 0);
        @(negedge Clock); chk("sa_ip1", oIP, 1);
        chk("sa_we1", oWriteEnable, 1); chk("sa_wa1", oWriteAddr, 1); chk("sa_wd1", oWriteData, 16'h0005);
        @(negedge Clock); chk("sa_ip2", oIP, 2);
        chk("sa_we2", oWriteEnable, 1); chk("sa_wa2", oWriteAddr, 2); chk("sa_wd2", oWriteData, 16'h000A);

        // Three nested calls unwind in LIFO order.
        clear_rom();
        rom[8'h00] = mk(4'd6, 8'h10, 8'h00, 8'h00);
        rom[8'h10] = mk(4'd6, 8'h20, 8'h00, 8'h00);
        rom[8'h20] = mk(4'd6, 8'h30, 8'h00, 8'h00);
        rom[8'h30] = mk(4'd7, 8'h00, 8'h00, 8'h00);
        rom[8'h21] = mk(4'd7, 8'h00, 8'h00, 8'h00);
        rom[8'h11] = mk(4'd7, 8'h00, 8'h00, 8'h00);
        reset_dut();
        begin
            logic [15:0] seq [8];
            seq = '{16'h00, 16'h10, 16'h20, 16'h30, 16'h21, 16'h11, 16'h01, 16'h02};
            for (int c = 0; c < 8; c++) begin
                @(negedge Clock);
                chk($sformatf("nest_ip%0d", c), oIP, seq[c]);
            end
        end
        chk("nest_fault", oStackFault, 2'b00);

        // Five nested calls: fifth overflows but still branches; top stays the fourth return.
        clear_rom();
        rom[8'h00] = mk(4'd6, 8'h10, 8'h00, 8'h00);
        rom[8'h10] = mk(4'd6, 8'h20, 8'h00, 8'h00);
        rom[8'h20] = mk(4'd6, 8'h30, 8'h00, 8'h00);
        rom[8'h30] = mk(4'd6, 8'h40, 8'h00, 8'h00);
        rom[8'h40] = mk(4'd6, 8'h50, 8'h00, 8'h00);
        rom[8'h50] = mk(4'd7, 8'h00, 8'h00, 8'h00);
        reset_dut();
        repeat (5) @(negedge Clock);
        chk("ovf_ip4", oIP, 16'h40);
        chk("ovf_fault4", oStackFault, 2'b00);
        @(negedge Clock);
        chk("ovf_ip5", oIP, 16'h50);
        @(negedge Clock);
        chk("ovf_fault6", oStackFault, 2'b01);
        chk("ovf_ret_ip", oIP, 16'h31);

        // RET on empty stack (reset_dut also confirms the overflow flag cleared).
        clear_rom();
        rom[0] = mk(4'd7, 8'h00, 8'h00, 8'h00);
        reset_dut();
        @(negedge Clock);
        @(negedge Clock); chk("unf_ip1", oIP, 1);
        @(negedge Clock); chk("unf_fault", oStackFault, 2'b10); chk("unf_ip2", oIP, 2);

        // OUT strobe with forwarded operand, then IN.
        clear_rom();
        iIOData = 16'h1234;
        rom[0] = mk(4'd3, 8'h03, 8'h00, 8'h07);
        rom[1] = mk(4'd10, 8'h03, 8'h03, 8'h00);
        rom[2] = mk(4'd11, 8'h05, 8'h00, 8'h00);
        reset_dut();
        @(negedge Clock);
        @(negedge Clock); chk("io_c1", oIOWrite, 0);
        @(negedge Clock);
        chk("io_c2", oIOWrite, 1); chk("io_sel", oIOSel, 3); chk("io_data", oIOData, 7);
        @(negedge Clock);
        chk("io_c3", oIOWrite, 0); chk("in_we", oWriteEnable, 1);
        chk("in_wa", oWriteAddr, 5); chk("in_wd", oWriteData, 16'h1234);
        @(negedge Clock); chk("io_c4", oIOWrite, 0);

        // HALT at 9 freezes oIP at 10; one reset cycle restarts from 0.
        clear_rom();
        rom[9]  = mk(4'd15, 8'h00, 8'h00, 8'h00);
        rom[10] = mk(4'd3, 8'h01, 8'h12, 8'h34);
        reset_dut();
        repeat (11) @(negedge Clock);
        chk("halt_ip", oIP, 10);
        begin
            int bad_ip = 0, bad_we = 0, bad_h = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge Clock);
                if (oIP !== 16'd10) bad_ip++;
                if (oWriteEnable !== 1'b0) bad_we++;
                if (oHalted !== 1'b1) bad_h++;
            end
            chk("halt_hold_ip", bad_ip, 0);
            chk("halt_hold_we", bad_we, 0);
            chk("halt_hold_flag", bad_h, 0);
        end
        @(posedge Clock); #1 Reset = 1'b0;
        @(posedge Clock); #1 Reset = 1'b1;
        @(negedge Clock); chk("halt_rst_ip", oIP, 0); chk("halt_rst_flag", oHalted, 0);
        @(negedge Clock); chk("halt_rst_ip1", oIP, 1);

        // Random programs against the ISA model.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) begin
                logic [4:0] r;
                logic [3:0] op;
                r = 5'($urandom_range(0, 31));
                case (r)
                    0, 1, 2, 3, 27, 28: op = 4'd1;
                    4, 5, 6:            op = 4'd2;
                    7, 8:               op = 4'd8;
                    9, 10:              op = 4'd9;
                    11, 12, 13:         op = 4'd3;
                    14, 15:             op = 4'd4;
                    16:                 op = 4'd5;
                    17, 18:             op = 4'd6;
                    19, 20, 29:         op = 4'd7;
                    21, 30:             op = 4'd10;
                    22, 31:             op = 4'd11;
                    23:                 op = 4'd0;
                    24:                 op = 4'd12;
                    25:                 op = 4'd13;
                    default:            op = 4'd14;
                endcase
                if (op == 4'd4 || op == 4'd5 || op == 4'd6)
                    rom[i] = mk(op, 8'($urandom_range(0, 63)), 8'($urandom_range(0, 15)),
                                8'($urandom_range(0, 15)));
                else if (op == 4'd3)
                    rom[i] = mk(op, 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
                else
                    rom[i] = mk(op, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                                8'($urandom_range(0, 15)));
            end
            if (p % 2 == 0) rom[$urandom_range(0, 63)] = mk(4'd15, 8'h00, 8'h00, 8'h00);
            for (int i = 0; i < 256; i++) begin
                ram_init[i] = 16'($urandom);
                m_mem[i] = ram_init[i];
            end
            m_ip = '0;
            m_stk.delete();
            m_flt = '0;
            m_halt = 0;
            reset_dut();
            @(negedge Clock);
            chk($sformatf("rnd%0d_ip0", p), oIP, 0);
            for (int c = 1; c < 250; c++) begin
                @(posedge Clock); #1 iIOData = 16'($urandom);
                @(negedge Clock);
                model_cycle(c);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
